usb_ep_router: RTL and testbench
================================

Name: usb_ep_router

Overview:
- Parametrised N-endpoint bulk-data router between the USB protocol core's single bulk stream pair and NUM_EPS user AXI4-Stream endpoint channels.
- IN direction (EP -> host): packet-atomic N:1 mux, selected by the token's endpoint number. Packets longer than MAX_PACKET are split with a forced tlast.
- OUT direction (host -> EP): 1:N demux by endpoint number. Data for an unmapped endpoint is discarded.
- Sits inside the top-level ULPI/AXI wrapper. It replaces the hard-wired single bulk endpoint.

Parameters:
- NUM_EPS, 2, number of bulk channels, 1..15; channel i serves endpoint EP_BASE+i.
- EP_BASE, 1, USB endpoint number of channel 0, 1..15.
- WIDTH, 8, data width in bits.
- MAX_PACKET, 512, maximum bytes per IN packet, 8..1024.

Ports:
- clock  in  1  USB-domain clock (ULPI 60 MHz).
- reset  in  1  Asynchronous reset, active-high.
- tok_start_i  in  1  One-cycle pulse: a token has been decoded; sample dir and endpoint.
- tok_dir_i  in  1  1 = IN token, 0 = OUT token.
- tok_endp_i  in  4  Endpoint number from the token.
- abort_i  in  1  Terminate any transfer immediately (bus reset, timeout).
- busy_o  out  1  High whenever state != IDLE.
- done_o  out  1  One-cycle pulse when a transfer completes normally.
- stall_o  out  1  One-cycle pulse for an IN token to an unmapped endpoint.
- ep_ready_o  out  NUM_EPS  Per-channel s_axis_tvalid_i; the core uses it to choose between NAK and data.
- s_axis_tvalid_i/tready_o/tlast_i  in/out/in  NUM_EPS each  Per-channel IN streams.
- s_axis_tdata_i  in  NUM_EPS*WIDTH  Per-channel IN data; channel i occupies [i*WIDTH +: WIDTH].
- usb_tvalid_o/tready_i/tlast_o  out/in/out  1  Merged IN stream to the protocol core.
- usb_tdata_o  out  WIDTH  Merged IN data.
- usb_tvalid_i/tready_o/tlast_i  in/out/in  1  OUT stream from the protocol core.
- usb_tdata_i  in  WIDTH  OUT data.
- m_axis_tvalid_o/tready_i/tlast_o  out/in/out  NUM_EPS each  Per-channel OUT streams.
- m_axis_tdata_o  out  NUM_EPS*WIDTH  Per-channel OUT data; shared bus, the data of the active channel.

Behaviour:
- Reset values: state IDLE, select 0, byte count 0. All tvalid/tready/tlast/done/stall/busy outputs 0. Data outputs 0.
- FSM states: IDLE, IN, OUT, DROP.
- IDLE, on tok_start_i, compute idx = tok_endp_i - EP_BASE; idx is valid when 0 <= idx < NUM_EPS.
  - IN token, valid idx: latch sel = idx, count = 0, go to IN.
  - IN token, invalid idx: stall_o pulses next cycle; stay in IDLE.
  - OUT token, valid idx: go to OUT.
  - OUT token, invalid idx: go to DROP.
- tok_start_i in any state other than IDLE: ignored.
- Data path: combinational, zero latency. Only sel and state are registered.
- IN state:
  - usb_tvalid_o = s_axis_tvalid_i[sel]; usb_tdata_o = channel sel data.
  - s_axis_tready_o[sel] = usb_tready_i; all other channels see tready 0.
  - usb_tlast_o = s_axis_tlast_i[sel] OR (count == MAX_PACKET-1).
  - On each accepted beat (valid & ready), count increments. count width is clog2(MAX_PACKET); it never wraps in use.
  - On an accepted beat with usb_tlast_o high: done_o pulses next cycle; go to IDLE.
  - A forced tlast does not consume the upstream tlast. The remainder goes out in the next IN transfer.
- OUT state:
  - m_axis_tvalid_o[sel] = usb_tvalid_i; m_axis_tlast_o[sel] = usb_tlast_i; usb_tready_o = m_axis_tready_i[sel].
  - On the accepted tlast beat: done_o pulses; go to IDLE.
- DROP state: usb_tready_o = 1; discard beats. On the accepted tlast beat: go to IDLE, no done_o.
- abort_i, any state: go to IDLE next cycle; no done_o. A partially transferred IN packet is not replayed.
- abort_i has priority over a simultaneous completion or tok_start_i.
- In IDLE, all handshake outputs are 0.

Optional Feature:
- Macro: USB_EP_ROUTER_STATS_EN.
- Defined:
  - Adds output stat_pkts_o, NUM_EPS*16 bits: per-channel count of completed IN+OUT transfers, wrapping 16'hFFFF -> 0.
  - Adds output stat_drop_o, 16 bits: count of beats discarded in DROP, saturating at 16'hFFFF.
  - Both counters clear on reset.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package/header usb_ep_router_defs holds:
  - state encodings ST_IDLE/ST_IN/ST_OUT/ST_DROP;
  - TOK_DIR_IN = 1, TOK_DIR_OUT = 0;
  - endpoint-number width of 4.
- One sub-module: usb_ep_pkt_limit, the byte counter that generates the forced tlast. Parameter MAX_PACKET. Inputs: beat, clear. Output: last.

Test Plan:
- NUM_EPS=2, EP_BASE=1: IN token endp 2, channel 1 presents 4 bytes A0..A3 with tlast on A3 -> usb stream carries A0..A3, tlast on A3; done_o pulses once; channel 0 tready stays 0.
- MAX_PACKET=8, channel 0 presents 12 bytes with tlast on byte 12:
  - first IN -> 8 bytes out, tlast forced on byte 8;
  - second IN -> 4 bytes, tlast from upstream.
- OUT token endp 1, 3 bytes 11,22,33 with m_axis_tready_i[0] toggling 1,0,1 -> channel 0 receives all 3 bytes in order; usb_tready_o follows; channel 1 tvalid stays 0.
- OUT token endp 7 (unmapped) with 5 bytes -> all accepted, none forwarded, no done_o; stats build: stat_drop_o = 5. IN token endp 0 -> stall_o pulses once.
- abort_i asserted after 2 of 6 IN bytes -> busy_o low next cycle, no done_o; a new IN token resumes at byte 3.
- reset asserted mid-OUT transfer -> all outputs 0 within the same cycle (asynchronous); state IDLE after release.

Source files
------------

// File: rtl/usb_ep_router_pkg.sv
// usb_ep_router shared definitions: FSM states, token direction codes,
// endpoint-number width.
package usb_ep_router_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IN   = 2'd1,
    ST_OUT  = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  localparam logic TOK_DIR_IN  = 1'b1;
  localparam logic TOK_DIR_OUT = 1'b0;
  localparam int   EP_W        = 4;

endpackage

// File: rtl/usb_ep_router_pkt_limit.sv
// usb_ep_pkt_limit: IN byte counter; last flags the final beat that
// still fits in one MAX_PACKET-sized USB packet.
module usb_ep_pkt_limit #(
  parameter int MAX_PACKET = 512
) (
  input  logic clock,
  input  logic reset,
  input  logic beat,
  input  logic clear,
  output logic last
);

  localparam int CW = $clog2(MAX_PACKET);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PACKET - 1);

  logic [CW-1:0] cnt;

  // count accepted beats; clear wins so a new transfer starts at 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (beat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/usb_ep_router.sv
// usb_ep_router: N-endpoint bulk router, IN N:1 mux / OUT 1:N demux.
// Optional counters: define USB_EP_ROUTER_STATS_EN.
module usb_ep_router
  import usb_ep_router_defs::*;
#(
  parameter int NUM_EPS    = 2,
  parameter int EP_BASE    = 1,
  parameter int WIDTH      = 8,
  parameter int MAX_PACKET = 512
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tok_start_i,
  input  logic                     tok_dir_i,
  input  logic [EP_W-1:0]          tok_endp_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     stall_o,
  output logic [NUM_EPS-1:0]       ep_ready_o,
`ifdef USB_EP_ROUTER_STATS_EN
  output logic [NUM_EPS*16-1:0]    stat_pkts_o,
  output logic [15:0]              stat_drop_o,
`endif
  input  logic [NUM_EPS-1:0]       s_axis_tvalid_i,
  output logic [NUM_EPS-1:0]       s_axis_tready_o,
  input  logic [NUM_EPS-1:0]       s_axis_tlast_i,
  input  logic [NUM_EPS*WIDTH-1:0] s_axis_tdata_i,
  output logic                     usb_tvalid_o,
  input  logic                     usb_tready_i,
  output logic                     usb_tlast_o,
  output logic [WIDTH-1:0]         usb_tdata_o,
  input  logic                     usb_tvalid_i,
  output logic                     usb_tready_o,
  input  logic                     usb_tlast_i,
  input  logic [WIDTH-1:0]         usb_tdata_i,
  output logic [NUM_EPS-1:0]       m_axis_tvalid_o,
  input  logic [NUM_EPS-1:0]       m_axis_tready_i,
  output logic [NUM_EPS-1:0]       m_axis_tlast_o,
  output logic [WIDTH-1:0]         m_axis_tdata_o
);

  localparam int SW = (NUM_EPS > 1) ? $clog2(NUM_EPS) : 1;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          done_d, stall_d;
  logic          in_beat, pkt_clear, pkt_last;
  logic [4:0]    endp_ext;
  logic          idx_ok;
  logic [SW-1:0] idx;

  assign endp_ext = {1'b0, tok_endp_i};
  assign idx_ok   = (endp_ext >= 5'(EP_BASE)) &&
                    (endp_ext <  5'(EP_BASE + NUM_EPS));
  assign idx      = SW'(endp_ext - 5'(EP_BASE));

  assign busy_o     = (state_q != ST_IDLE);
  assign ep_ready_o = s_axis_tvalid_i;
  assign pkt_clear  = (state_q != ST_IN);

  usb_ep_pkt_limit #(
    .MAX_PACKET(MAX_PACKET)
  ) u_limit (
    .clock(clock),
    .reset(reset),
    .beat (in_beat),
    .clear(pkt_clear),
    .last (pkt_last)
  );

  // state, channel select and the registered completion pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      done_o  <= 1'b0;
      stall_o <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      done_o  <= done_d;
      stall_o <= stall_d;
    end
  end

  // token decode, routing and transfer-end detection
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    done_d          = 1'b0;
    stall_d         = 1'b0;
    in_beat         = 1'b0;
    s_axis_tready_o = '0;
    usb_tvalid_o    = 1'b0;
    usb_tlast_o     = 1'b0;
    usb_tdata_o     = '0;
    usb_tready_o    = 1'b0;
    m_axis_tvalid_o = '0;
    m_axis_tlast_o  = '0;
    m_axis_tdata_o  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (tok_start_i) begin
          if (tok_dir_i == TOK_DIR_IN) begin
            if (idx_ok) begin
              state_d = ST_IN;
              sel_d   = idx;
            end else begin
              stall_d = 1'b1;
            end
          end else if (idx_ok) begin
            state_d = ST_OUT;
            sel_d   = idx;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_IN: begin
        usb_tvalid_o = s_axis_tvalid_i[sel_q];
        usb_tdata_o  = s_axis_tdata_i[int'(sel_q)*WIDTH +: WIDTH];
        usb_tlast_o  = s_axis_tlast_i[sel_q] | pkt_last;
        s_axis_tready_o[sel_q] = usb_tready_i;
        in_beat = usb_tvalid_o & usb_tready_i;
        if (in_beat && usb_tlast_o) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        m_axis_tvalid_o[sel_q] = usb_tvalid_i;
        m_axis_tlast_o[sel_q]  = usb_tlast_i;
        m_axis_tdata_o         = usb_tdata_i;
        usb_tready_o           = m_axis_tready_i[sel_q];
        if (usb_tvalid_i && usb_tready_o && usb_tlast_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        usb_tready_o = 1'b1;
        if (usb_tvalid_i && usb_tlast_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      stall_d = 1'b0;
    end
  end

`ifdef USB_EP_ROUTER_STATS_EN
  logic drop_beat;
  assign drop_beat = (state_q == ST_DROP) & usb_tvalid_i;

  // per-channel transfer counts (wrapping) and dropped beats (saturating)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_pkts_o <= '0;
      stat_drop_o <= '0;
    end else begin
      if (done_d) begin
        stat_pkts_o[int'(sel_q)*16 +: 16] <=
          stat_pkts_o[int'(sel_q)*16 +: 16] + 16'd1;
      end
      if (drop_beat && stat_drop_o != 16'hFFFF) begin
        stat_drop_o <= stat_drop_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_usb_ep_router.sv
// Directed bench for usb_ep_router (NUM_EPS=2, EP_BASE=1, MAX_PACKET=8).
// Token decode table plus hand sequences for multi-cycle cases.
module tb_usb_ep_router;

  logic        clock = 1'b0;
  logic        reset;
  logic        tok_start_i, tok_dir_i, abort_i;
  logic [3:0]  tok_endp_i;
  logic        busy_o, done_o, stall_o;
  logic [1:0]  ep_ready_o;
  logic [1:0]  s_axis_tvalid_i, s_axis_tready_o, s_axis_tlast_i;
  logic [15:0] s_axis_tdata_i;
  logic        usb_tvalid_o, usb_tready_i, usb_tlast_o;
  logic [7:0]  usb_tdata_o;
  logic        usb_tvalid_i, usb_tready_o, usb_tlast_i;
  logic [7:0]  usb_tdata_i;
  logic [1:0]  m_axis_tvalid_o, m_axis_tready_i, m_axis_tlast_o;
  logic [7:0]  m_axis_tdata_o;
`ifdef USB_EP_ROUTER_STATS_EN
  logic [31:0] stat_pkts_o;
  logic [15:0] stat_drop_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  usb_ep_router #(
    .NUM_EPS(2), .EP_BASE(1), .WIDTH(8), .MAX_PACKET(8)
  ) dut (
    .clock(clock), .reset(reset),
    .tok_start_i(tok_start_i), .tok_dir_i(tok_dir_i),
    .tok_endp_i(tok_endp_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o),
    .ep_ready_o(ep_ready_o),
`ifdef USB_EP_ROUTER_STATS_EN
    .stat_pkts_o(stat_pkts_o), .stat_drop_o(stat_drop_o),
`endif
    .s_axis_tvalid_i(s_axis_tvalid_i),
    .s_axis_tready_o(s_axis_tready_o),
    .s_axis_tlast_i(s_axis_tlast_i),
    .s_axis_tdata_i(s_axis_tdata_i),
    .usb_tvalid_o(usb_tvalid_o), .usb_tready_i(usb_tready_i),
    .usb_tlast_o(usb_tlast_o), .usb_tdata_o(usb_tdata_o),
    .usb_tvalid_i(usb_tvalid_i), .usb_tready_o(usb_tready_o),
    .usb_tlast_i(usb_tlast_i), .usb_tdata_i(usb_tdata_i),
    .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tready_i(m_axis_tready_i),
    .m_axis_tlast_o(m_axis_tlast_o),
    .m_axis_tdata_o(m_axis_tdata_o)
  );

  typedef struct {
    logic       dir;
    logic [3:0] endp;
    logic       busy;
    logic       stall;
    logic [1:0] sready;
    logic       uready;
  } tok_vec_t;

  tok_vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic token(input logic dir, input logic [3:0] endp);
    tok_start_i = 1'b1;
    tok_dir_i   = dir;
    tok_endp_i  = endp;
    step();
    tok_start_i = 1'b0;
    #1;
  endtask

  task automatic in_beat(input int ch, input logic [7:0] d,
                         input logic last, input logic exp_last);
    s_axis_tvalid_i[ch]        = 1'b1;
    s_axis_tdata_i[ch*8 +: 8]  = d;
    s_axis_tlast_i[ch]         = last;
    usb_tready_i               = 1'b1;
    #1;
    chk("in_valid", 32'(usb_tvalid_o), 1);
    chk("in_data", 32'(usb_tdata_o), 32'(d));
    chk("in_last", 32'(usb_tlast_o), 32'(exp_last));
    chk("in_sready", 32'(s_axis_tready_o), 32'(2'b01 << ch));
    chk("in_done_early", 32'(done_o), 0);
    step();
    s_axis_tvalid_i = '0;
    s_axis_tlast_i  = '0;
  endtask

  task automatic out_beat(input logic [7:0] d, input logic last,
                          input logic [1:0] mr, input logic exp_rdy,
                          input logic [1:0] exp_mv);
    usb_tvalid_i    = 1'b1;
    usb_tdata_i     = d;
    usb_tlast_i     = last;
    m_axis_tready_i = mr;
    #1;
    chk("out_uready", 32'(usb_tready_o), 32'(exp_rdy));
    chk("out_mvalid", 32'(m_axis_tvalid_o), 32'(exp_mv));
    chk("out_mlast", 32'(m_axis_tlast_o), last ? 32'(exp_mv) : 0);
    chk("out_mdata", 32'(m_axis_tdata_o),
        (exp_mv != 2'b00) ? 32'(d) : 0);
    step();
    usb_tvalid_i = 1'b0;
    usb_tlast_i  = 1'b0;
  endtask

  initial begin
    tv[0] = '{1'b1, 4'd0,  1'b0, 1'b1, 2'b00, 1'b0};
    tv[1] = '{1'b1, 4'd1,  1'b1, 1'b0, 2'b01, 1'b0};
    tv[2] = '{1'b1, 4'd2,  1'b1, 1'b0, 2'b10, 1'b0};
    tv[3] = '{1'b1, 4'd3,  1'b0, 1'b1, 2'b00, 1'b0};
    tv[4] = '{1'b0, 4'd1,  1'b1, 1'b0, 2'b00, 1'b0};
    tv[5] = '{1'b0, 4'd2,  1'b1, 1'b0, 2'b00, 1'b1};
    tv[6] = '{1'b0, 4'd7,  1'b1, 1'b0, 2'b00, 1'b1};
    tv[7] = '{1'b1, 4'd15, 1'b0, 1'b1, 2'b00, 1'b0};

    reset           = 1'b1;
    tok_start_i     = 1'b0;
    tok_dir_i       = 1'b0;
    tok_endp_i      = '0;
    abort_i         = 1'b0;
    s_axis_tvalid_i = '0;
    s_axis_tlast_i  = '0;
    s_axis_tdata_i  = '0;
    usb_tready_i    = 1'b0;
    usb_tvalid_i    = 1'b0;
    usb_tlast_i     = 1'b0;
    usb_tdata_i     = '0;
    m_axis_tready_i = '0;
    step();
    step();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_uvalid", 32'(usb_tvalid_o), 0);
    chk("rst_udata", 32'(usb_tdata_o), 0);
    chk("rst_mvalid", 32'(m_axis_tvalid_o), 0);
    reset = 1'b0;
    step();

    usb_tready_i    = 1'b1;
    m_axis_tready_i = 2'b10;
    for (int i = 0; i < 8; i++) begin
      token(tv[i].dir, tv[i].endp);
      chk($sformatf("tok%0d_busy", i), 32'(busy_o), 32'(tv[i].busy));
      chk($sformatf("tok%0d_stall", i), 32'(stall_o), 32'(tv[i].stall));
      chk($sformatf("tok%0d_sready", i), 32'(s_axis_tready_o),
          32'(tv[i].sready));
      chk($sformatf("tok%0d_uready", i), 32'(usb_tready_o),
          32'(tv[i].uready));
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      #1;
      chk($sformatf("tok%0d_idle", i), 32'(busy_o), 0);
      chk($sformatf("tok%0d_stall_gone", i), 32'(stall_o), 0);
      chk($sformatf("tok%0d_nodone", i), 32'(done_o), 0);
    end
    usb_tready_i    = 1'b0;
    m_axis_tready_i = 2'b00;

    token(1'b1, 4'd2);
    for (int i = 0; i < 4; i++)
      in_beat(1, 8'hA0 + 8'(i), i == 3, i == 3);
    chk("seq1_done", 32'(done_o), 1);
    chk("seq1_busy", 32'(busy_o), 0);
    step();
    chk("seq1_done_once", 32'(done_o), 0);

    token(1'b1, 4'd1);
    for (int i = 0; i < 8; i++)
      in_beat(0, 8'h10 + 8'(i), 1'b0, i == 7);
    chk("seq2a_done", 32'(done_o), 1);
    chk("seq2a_busy", 32'(busy_o), 0);
    token(1'b1, 4'd1);
    for (int i = 8; i < 12; i++)
      in_beat(0, 8'h10 + 8'(i), i == 11, i == 11);
    chk("seq2b_done", 32'(done_o), 1);

    token(1'b0, 4'd1);
    out_beat(8'h11, 1'b0, 2'b01, 1'b1, 2'b01);
    out_beat(8'h22, 1'b0, 2'b00, 1'b0, 2'b01);
    out_beat(8'h22, 1'b0, 2'b01, 1'b1, 2'b01);
    out_beat(8'h33, 1'b1, 2'b01, 1'b1, 2'b01);
    chk("seq3_done", 32'(done_o), 1);
    chk("seq3_busy", 32'(busy_o), 0);
    m_axis_tready_i = 2'b00;

    token(1'b0, 4'd7);
    for (int i = 0; i < 5; i++)
      out_beat(8'hD0 + 8'(i), i == 4, 2'b00, 1'b1, 2'b00);
    chk("drop_nodone", 32'(done_o), 0);
    chk("drop_busy", 32'(busy_o), 0);
    token(1'b1, 4'd0);
    chk("stall_pulse", 32'(stall_o), 1);
    step();
    chk("stall_once", 32'(stall_o), 0);

    token(1'b1, 4'd2);
    in_beat(1, 8'hB0, 1'b0, 1'b0);
    in_beat(1, 8'hB1, 1'b0, 1'b0);
    s_axis_tvalid_i[1] = 1'b1;
    s_axis_tdata_i[15:8] = 8'hB2;
    usb_tready_i = 1'b0;
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_nodone", 32'(done_o), 0);
    step();
    chk("abort_nodone2", 32'(done_o), 0);
    token(1'b1, 4'd2);
    for (int i = 2; i < 6; i++)
      in_beat(1, 8'hB0 + 8'(i), i == 5, i == 5);
    chk("resume_done", 32'(done_o), 1);

`ifdef USB_EP_ROUTER_STATS_EN
    chk("stat_drop", 32'(stat_drop_o), 5);
    chk("stat_pkts0", 32'(stat_pkts_o[15:0]), 3);
    chk("stat_pkts1", 32'(stat_pkts_o[31:16]), 2);
`endif

    token(1'b0, 4'd2);
    usb_tvalid_i    = 1'b1;
    usb_tdata_i     = 8'h5A;
    m_axis_tready_i = 2'b10;
    #1;
    chk("pre_rst_mvalid", 32'(m_axis_tvalid_o), 32'(2'b10));
    chk("pre_rst_mdata", 32'(m_axis_tdata_o), 32'h5A);
    chk("pre_rst_uready", 32'(usb_tready_o), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_mvalid", 32'(m_axis_tvalid_o), 0);
    chk("async_mdata", 32'(m_axis_tdata_o), 0);
    chk("async_uready", 32'(usb_tready_o), 0);
    chk("async_busy", 32'(busy_o), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step();
    chk("post_rst_busy", 32'(busy_o), 0);
    chk("post_rst_uready", 32'(usb_tready_o), 0);
    chk("post_rst_mvalid", 32'(m_axis_tvalid_o), 0);
`ifdef USB_EP_ROUTER_STATS_EN
    chk("post_rst_stat", 32'(stat_drop_o), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
